// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared state encoding and sizing helpers for the
// digit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Counter width for n digit steps: clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells.
// Besides the sum and carry-out it exposes the carry into the top bit,
// which the parent uses for signed-overflow detection.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co    = c[DIGIT];
    c_msb = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor, DIGIT bits per clock,
// least-significant digit first, with valid/ready on both sides.
// Optional macro SERIAL_ADD_SUB_FLAGS_EN enables the ovf and zero flags;
// without it both flags read 0 and their logic is removed.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_add_sub: DIGIT must divide WIDTH exactly");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg;
  logic [DIGIT-1:0] d_sum;
  logic             d_co;
  logic             d_cmsb;
  logic             accept;
  logic             last_step;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .x     (a_sr[DIGIT-1:0]),
    .y     (b_sr[DIGIT-1:0]),
    .ci    (carry_reg),
    .sum   (d_sum),
    .co    (d_co),
    .c_msb (d_cmsb)
  );

  assign accept    = (state == ST_IDLE) && in_valid;
  assign last_step = (state == ST_RUN) && (cnt == LAST);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // The new digit enters at the top; after N steps the word is aligned.
  assign acc_next = WIDTH'({d_sum, acc} >> DIGIT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after N steps, DONE -> IDLE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and digit-serial datapath; subtraction folds into B inversion and carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_sr      <= a;
      b_sr      <= b ^ {WIDTH{sub}};
      carry_reg <= cin ^ sub;
      cnt       <= '0;
    end else if (state == ST_RUN) begin
      a_sr      <= a_sr >> DIGIT;
      b_sr      <= b_sr >> DIGIT;
      acc       <= acc_next;
      carry_reg <= d_co;
      cnt       <= cnt + 1'b1;
    end
  end

  // Result and carry-out registers load only on the final digit step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else if (last_step) begin
      s    <= acc_next;
      cout <= d_co;
    end
  end

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  // Status flags, taken from the final digit step alongside the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (last_step) begin
      ovf  <= d_co ^ d_cmsb;
      zero <= (acc_next == '0);
    end
  end
`else
  logic unused_c_msb;
  assign unused_c_msb = d_cmsb;
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed scoreboard bench for serial_add_sub.
// Main DUT is WIDTH=8/DIGIT=2; a second instance covers WIDTH=DIGIT=8.
module tb_serial_add_sub;

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
  logic [7:0] a, b, s;

  logic       in_valid2, in_ready2, sub2, cin2, out_valid2, out_ready2, cout2, ovf2, zero2;
  logic [7:0] a2, b2, s2;

  exp_t exp_q[$];
  exp_t exp_q2[$];

  int tests_run;
  int tests_failed;

  serial_add_sub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(8)) dut_n1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .cout(cout2), .ovf(ovf2), .zero(zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one operation into the main DUT, queues its expected result,
  // and returns #1 after the edge where out_valid rises (latency checked).
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                               input logic tcin, input logic [7:0] es, input logic ec,
                               input logic eo, input logic ez);
    exp_t e;
    int   cycles;
    cycles = 0;
    while (!in_ready && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; sub = tsub; cin = tcin; in_valid = 1'b1;
    e.s = es; e.cout = ec; e.ovf = eo & FLAGS; e.zero = ez & FLAGS;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("latency", cycles, 32'd4);
  endtask

  // Monitor for the main DUT: compare each accepted result with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_nonempty", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("s",    {24'd0, s},    {24'd0, e.s});
        checkOutput("cout", {31'd0, cout}, {31'd0, e.cout});
        checkOutput("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
        checkOutput("zero", {31'd0, zero}, {31'd0, e.zero});
      end
    end
  end

  // Monitor for the single-digit DUT.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid2 && out_ready2) begin
      if (exp_q2.size() == 0) begin
        checkOutput("n1_scoreboard_nonempty", exp_q2.size(), 32'd1);
      end else begin
        e = exp_q2.pop_front();
        checkOutput("n1_s",    {24'd0, s2},    {24'd0, e.s});
        checkOutput("n1_cout", {31'd0, cout2}, {31'd0, e.cout});
        checkOutput("n1_ovf",  {31'd0, ovf2},  {31'd0, e.ovf});
        checkOutput("n1_zero", {31'd0, zero2}, {31'd0, e.zero});
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   cycles;
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_s",         {24'd0, s},         32'd0);
    checkOutput("rst_cout",      {31'd0, cout},      32'd0);
    checkOutput("rst_ovf",       {31'd0, ovf},       32'd0);
    checkOutput("rst_zero",      {31'd0, zero},      32'd0);

    applyStimulus(8'h3C, 8'h0F, 1'b0, 1'b1, 8'h4C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h20, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h50, 8'h10, 1'b1, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure: result must hold and new operands must be ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_s_hold",    {24'd0, s},         32'h77);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_in_ready_after",  {31'd0, in_ready},  32'd1);
    checkOutput("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_s",         {24'd0, s},         32'd0);
    checkOutput("abort_cout",      {31'd0, cout},      32'd0);
    checkOutput("abort_ovf",       {31'd0, ovf},       32'd0);
    checkOutput("abort_zero",      {31'd0, zero},      32'd0);
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Single-digit instance: one RUN cycle.
    @(posedge clk); #1;
    cycles = 0;
    while (!in_ready2 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    a2 = 8'hAA; b2 = 8'h55; sub2 = 1'b0; cin2 = 1'b1; in_valid2 = 1'b1;
    e.s = 8'h00; e.cout = 1'b1; e.ovf = 1'b0; e.zero = FLAGS;
    exp_q2.push_back(e);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    cycles = 0;
    while (!out_valid2 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("n1_latency", cycles, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained",    exp_q.size(),  32'd0);
    checkOutput("n1_scoreboard_drained", exp_q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
